dual_ram_arbiter: RTL and testbench

Two-master arbiter that shares one simple-dual-port RAM (`dual_ram`: one write port, one read port, 1-cycle registered read, write-to-read forwarding on same-address collision) between two requesters. Typical pairing: core load/store unit (M0) and program loader or debug port (M1). Read and write ports are arbitrated independently, so one read and one write can proceed in the same cycle. Each port uses its own 2-way round-robin pointer. The block sits between the requesters and the `dual_ram` instance.

---
 rtl/dual_ram_arbiter_pkg.sv | 17 +
 rtl/rr_arb2.sv | 29 ++
 rtl/dual_ram_arbiter.sv | 119 +++++++++++
 tb/tb_dual_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_ram_arbiter_pkg.sv
// Shared definitions for the dual-port RAM arbiter: default widths, master ids.
// No logic of its own; the helper maps a master id to a one-hot grant vector.
// Imported by the round-robin sub-arbiter and the top level.
package dual_ram_arbiter_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 12;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // One-hot grant vector for a given master id (bit 0 = M0, bit 1 = M1).
  function automatic logic [1:0] mst_onehot(input logic id);
    return (id == MST_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// Grant is combinational from req and the pointer; pointer updates on the clock edge.
// Any grant hands priority to the other master, so a waiting master waits at most one cycle.
module rr_arb2
  import dual_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       prio
);

  // Uncontested requests pass straight through; a contested cycle goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) gnt = mst_onehot(prio);
      else              gnt = req;
    end
  end

  // After any grant, point at the master that did not win, contested or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               prio <= MST_M0;
    else if (gnt != 2'b00) prio <= gnt[0] ? MST_M1 : MST_M0;
  end

endmodule

// File: rtl/dual_ram_arbiter.sv
// Shares one simple-dual-port RAM between two masters; read and write ports arbitrated independently.
// Grant is combinational in the request cycle; read data valid exactly one cycle after a read grant.
// Ungranted masters hold their request stable; nothing is latched here, and same-address forwarding is the RAM's job.
module dual_ram_arbiter
  import dual_ram_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,

  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,

  output logic          ram_w_en_o,
  output logic [AW-1:0] ram_w_addr_o,
  output logic [DW-1:0] ram_w_data_o,
  output logic          ram_r_en_o,
  output logic [AW-1:0] ram_r_addr_o,
  input  logic [DW-1:0] ram_r_data_i
);

  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic       wr_prio;
  logic       rd_prio;
  logic       rd_vld;
  logic       rd_owner;

  // Pointers stay inside the sub-arbiters; the copies here are only for debug visibility.
  logic       unused_prio;
  assign unused_prio = wr_prio ^ rd_prio;

  // Split each master's single access onto the write or read port.
  always_comb begin
    wr_req = {m1_req_i &  m1_we_i, m0_req_i &  m0_we_i};
    rd_req = {m1_req_i & ~m1_we_i, m0_req_i & ~m0_we_i};
  end

  rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req),
    .gnt  (wr_gnt),
    .prio (wr_prio)
  );

  rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (rd_req),
    .gnt  (rd_gnt),
    .prio (rd_prio)
  );

  // A master has at most one access in flight per cycle, so OR of both ports is its grant.
  always_comb begin
    m0_gnt_o = wr_gnt[0] | rd_gnt[0];
    m1_gnt_o = wr_gnt[1] | rd_gnt[1];
  end

  // Write port mux; address and data are forced to zero when no write is granted.
  always_comb begin
    ram_w_en_o   = |wr_gnt;
    ram_w_addr_o = '0;
    ram_w_data_o = '0;
    if (wr_gnt[0]) begin
      ram_w_addr_o = m0_addr_i;
      ram_w_data_o = m0_wdata_i;
    end else if (wr_gnt[1]) begin
      ram_w_addr_o = m1_addr_i;
      ram_w_data_o = m1_wdata_i;
    end
  end

  // Read port mux; address forced to zero when no read is granted.
  always_comb begin
    ram_r_en_o   = |rd_gnt;
    ram_r_addr_o = '0;
    if (rd_gnt[0])      ram_r_addr_o = m0_addr_i;
    else if (rd_gnt[1]) ram_r_addr_o = m1_addr_i;
  end

  // Remember who owns the read in flight; reset drops it so no stale rvalid escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      rd_owner <= MST_M0;
    end else begin
      rd_vld   <= |rd_gnt;
      rd_owner <= rd_gnt[1] ? MST_M1 : MST_M0;
    end
  end

  // Steer the valid to the owner; data is the RAM output shared by both masters.
  always_comb begin
    m0_rvalid_o = rd_vld & (rd_owner == MST_M0);
    m1_rvalid_o = rd_vld & (rd_owner == MST_M1);
    m0_rdata_o  = ram_r_data_i;
    m1_rdata_o  = ram_r_data_i;
  end

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Directed and randomized checks of dual_ram_arbiter against a behavioural model.
// The bench owns a simple-dual-port RAM with same-address write forwarding.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dual_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_w_en, ram_r_en;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dual_ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_w_en_o(ram_w_en), .ram_w_addr_o(ram_w_addr), .ram_w_data_o(ram_w_data),
    .ram_r_en_o(ram_r_en), .ram_r_addr_o(ram_r_addr), .ram_r_data_i(ram_r_data)
  );

  // Bench-side RAM: registered read, write data forwarded on same-address collision.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_q;
  assign ram_r_data = ram_q;
  always @(posedge clk) begin
    if (ram_r_en) ram_q <= (ram_w_en && ram_w_addr == ram_r_addr) ? ram_w_data : ram_mem[ram_r_addr];
    if (ram_w_en) ram_mem[ram_w_addr] = ram_w_data;
  end

  // Reference model: memory image, last winner per port, and the read due next cycle.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_wr_last, ref_rd_last;
  logic          ref_rv0, ref_rv1;
  logic [DW-1:0] ref_rdata;
  logic          exp_wg0, exp_wg1, exp_rg0, exp_rg1, exp_g0, exp_g1;

  task automatic ref_reset();
    ref_wr_last = 1'b1;   // "M1 went last" so M0 is favoured first
    ref_rd_last = 1'b1;
    ref_rv0 = 1'b0;
    ref_rv1 = 1'b0;
  endtask

  // Expected grants: a sole requester wins; a contested port goes to whoever did not win last.
  task automatic ref_predict();
    logic cw0, cw1, cr0, cr1;
    cw0 = m0_req &&  m0_we;  cw1 = m1_req &&  m1_we;
    cr0 = m0_req && !m0_we;  cr1 = m1_req && !m1_we;
    exp_wg0 = cw0 && (!cw1 || ref_wr_last);
    exp_wg1 = cw1 && !exp_wg0;
    exp_rg0 = cr0 && (!cr1 || ref_rd_last);
    exp_rg1 = cr1 && !exp_rg0;
    exp_g0  = exp_wg0 || exp_rg0;
    exp_g1  = exp_wg1 || exp_rg1;
  endtask

  // Apply this cycle's accepted accesses; the write lands before the read looks at memory.
  task automatic ref_commit();
    if (exp_wg0) begin ref_mem[m0_addr] = m0_wdata; ref_wr_last = 1'b0; end
    else if (exp_wg1) begin ref_mem[m1_addr] = m1_wdata; ref_wr_last = 1'b1; end
    ref_rv0 = exp_rg0;
    ref_rv1 = exp_rg1;
    if (exp_rg0) begin ref_rdata = ref_mem[m0_addr]; ref_rd_last = 1'b0; end
    else if (exp_rg1) begin ref_rdata = ref_mem[m1_addr]; ref_rd_last = 1'b1; end
  endtask

  // Called at rising edge + 1: drive inputs, move to the falling edge, predict.
  task automatic drive(input logic q0, input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic q1, input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = q0; m0_we = e0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = e1; m1_addr = a1; m1_wdata = d1;
    #4;
    ref_predict();
  endtask

  task automatic next_cycle();
    ref_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 12'h005, 32'h0, 1'b1, 1'b0, 12'h006, 32'h0);
    total++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {m1_gnt, m0_gnt}); else passed++;
    total++; if ({ram_w_en, ram_r_en} !== 2'b00) $display("FAIL reset_ram_en: got %b want 00", {ram_w_en, ram_r_en}); else passed++;
    total++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {m1_rvalid, m0_rvalid}); else passed++;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    rst = 1'b0;
    ref_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b0, 12'h005, 32'h0, 1'b1, 1'b1, 12'h005, 32'hDEADBEEF);
    total++; if ({m1_gnt, m0_gnt} !== 2'b11) $display("FAIL collision_gnt: got %b want 11", {m1_gnt, m0_gnt}); else passed++;
    next_cycle();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    total++; if ({m1_rvalid, m0_rvalid} !== 2'b01) $display("FAIL collision_rvalid: got %b want 01", {m1_rvalid, m0_rvalid}); else passed++;
    total++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL collision_rdata: got %h want deadbeef", m0_rdata); else passed++;
    next_cycle();
  endtask

  task automatic test_write_contention();
    for (int i = 0; i < 4; i++) begin
      // Data only changes after the owner was granted, honouring the hold rule.
      drive(1'b1, 1'b1, 12'h010, 32'hA0A0_0000 + 32'((i + 1) / 2),
            1'b1, 1'b1, 12'h020, 32'hB0B0_0000 + 32'(i / 2));
      total++;
      if ({m1_gnt, m0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || {m1_gnt, m0_gnt} !== {exp_g1, exp_g0})
        $display("FAIL wr_order[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      else passed++;
      next_cycle();
    end
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA0A0_0001) $display("FAIL wr_final_m0: got %b/%h want 1/a0a00001", m0_rvalid, m0_rdata); else passed++;
    next_cycle();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB0B0_0001) $display("FAIL wr_final_m1: got %b/%h want 1/b0b00001", m1_rvalid, m1_rdata); else passed++;
    next_cycle();
  endtask

  task automatic test_read_contention();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
      else       drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      if (i < 4) begin
        total++; if ({m1_gnt, m0_gnt} !== {exp_g1, exp_g0}) $display("FAIL rd_gnt[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, {exp_g1, exp_g0}); else passed++;
      end
      total++; if ({m1_rvalid, m0_rvalid} !== {ref_rv1, ref_rv0}) $display("FAIL rd_rvalid[%0d]: got %b want %b", i, {m1_rvalid, m0_rvalid}, {ref_rv1, ref_rv0}); else passed++;
      if (i > 0) begin
        total++; if ((m0_rvalid ^ m1_rvalid) !== 1'b1) $display("FAIL rd_onehot[%0d]: got %b want exactly one", i, {m1_rvalid, m0_rvalid}); else passed++;
        total++; if (m0_rdata !== ref_rdata) $display("FAIL rd_data[%0d]: got %h want %h", i, m0_rdata, ref_rdata); else passed++;
      end
      next_cycle();
    end
  endtask

  task automatic test_m1_then_contest();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h3FF, 32'h0);
      total++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL m1_alone[%0d]: got %b want 10", i, {m1_gnt, m0_gnt}); else passed++;
      next_cycle();
    end
    drive(1'b1, 1'b0, 12'h005, 32'h0, 1'b1, 1'b0, 12'h3FF, 32'h0);
    total++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL contest_m0_wins: got %b want 01", {m1_gnt, m0_gnt}); else passed++;
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== ref_rdata) $display("FAIL m1_3ff_data: got %b/%h want 1/%h", m1_rvalid, m1_rdata, ref_rdata); else passed++;
    next_cycle();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h3FF, 32'h0);
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) $display("FAIL contest_m0_data: got %b/%h want 1/deadbeef", m0_rvalid, m0_rdata); else passed++;
    next_cycle();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b1, 12'h100, 32'h1234_5678, 1'b0, 1'b0, 12'h0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 12'h100, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    total++; if (m0_gnt !== 1'b1) $display("FAIL midrd_gnt: got %b want 1", m0_gnt); else passed++;
    ref_commit();
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 12'h010, 32'h1, 1'b1, 1'b1, 12'h020, 32'h2);
      total++; if ({m1_gnt, m0_gnt, ram_w_en, ram_r_en} !== 4'b0000) $display("FAIL midrd_rst_gnt[%0d]: got %b want 0000", i, {m1_gnt, m0_gnt, ram_w_en, ram_r_en}); else passed++;
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL midrd_rvalid[%0d]: got %b want 00", i, {m1_rvalid, m0_rvalid}); else passed++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ref_reset();
    drive(1'b1, 1'b1, 12'h011, 32'h55, 1'b1, 1'b1, 12'h021, 32'h66);
    total++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL midrd_wr_prio: got %b want 01", {m1_gnt, m0_gnt}); else passed++;
    total++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL midrd_no_rvalid: got %b want 00", {m1_rvalid, m0_rvalid}); else passed++;
    next_cycle();
    drive(1'b1, 1'b0, 12'h011, 32'h0, 1'b1, 1'b0, 12'h021, 32'h0);
    total++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL midrd_rd_prio: got %b want 01", {m1_gnt, m0_gnt}); else passed++;
    next_cycle();
  endtask

  task automatic test_idle();
    drive(1'b0, 1'b1, 12'h7AB, 32'hFFFF_FFFF, 1'b0, 1'b0, 12'h456, 32'h0);
    total++; if ({ram_w_en, ram_r_en, m1_gnt, m0_gnt} !== 4'b0000) $display("FAIL idle_en: got %b want 0000", {ram_w_en, ram_r_en, m1_gnt, m0_gnt}); else passed++;
    total++; if ({ram_w_addr, ram_r_addr, ram_w_data} !== '0) $display("FAIL idle_bus: got %h/%h/%h want 0", ram_w_addr, ram_r_addr, ram_w_data); else passed++;
    next_cycle();
    drive(1'b1, 1'b1, 12'h012, 32'h77, 1'b1, 1'b1, 12'h022, 32'h88);
    total++; if ({m1_gnt, m0_gnt} !== {exp_g1, exp_g0}) $display("FAIL idle_ptr_kept: got %b want %b", {m1_gnt, m0_gnt}, {exp_g1, exp_g0}); else passed++;
    next_cycle();
  endtask

  task automatic test_random();
    logic          p_req [2];
    logic          p_we  [2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_dat [2];
    for (int m = 0; m < 2; m++) p_req[m] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m]) begin
          p_req[m]  = ($urandom_range(3) != 0);
          p_we[m]   = $urandom_range(1) == 1;
          p_addr[m] = AW'($urandom_range(7));
          p_dat[m]  = $urandom;
        end
      end
      drive(p_req[0], p_we[0], p_addr[0], p_dat[0], p_req[1], p_we[1], p_addr[1], p_dat[1]);
      total++; if ({m1_gnt, m0_gnt} !== {exp_g1, exp_g0}) $display("FAIL rnd_gnt[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, {exp_g1, exp_g0}); else passed++;
      total++; if ({ram_w_en, ram_r_en} !== {exp_wg0 | exp_wg1, exp_rg0 | exp_rg1}) $display("FAIL rnd_en[%0d]: got %b want %b", i, {ram_w_en, ram_r_en}, {exp_wg0 | exp_wg1, exp_rg0 | exp_rg1}); else passed++;
      total++; if ({m1_rvalid, m0_rvalid} !== {ref_rv1, ref_rv0}) $display("FAIL rnd_rvalid[%0d]: got %b want %b", i, {m1_rvalid, m0_rvalid}, {ref_rv1, ref_rv0}); else passed++;
      if (ref_rv0 || ref_rv1) begin
        total++; if (m0_rdata !== ref_rdata) $display("FAIL rnd_rdata[%0d]: got %h want %h", i, m0_rdata, ref_rdata); else passed++;
      end
      if (exp_g0) p_req[0] = 1'b0;
      if (exp_g1) p_req[1] = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ram_mem[a] = '0;
      ref_mem[a] = '0;
    end
    ref_reset();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_collision();
    test_write_contention();
    test_read_contention();
    test_m1_then_contest();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
